// File: rtl/attn_sched_pkg.sv
// Shared types for the attention tile scheduler: FSM state encoding and load-target select.
package attn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_K,
    S_LD_V,
    S_LD_Q,
    S_COMPUTE,
    S_DRAIN,
    S_FIN
  } sched_state_t;

  typedef enum logic [1:0] {
    LD_SEL_K = 2'd0,
    LD_SEL_V = 2'd1,
    LD_SEL_Q = 2'd2
  } ld_sel_t;

  function automatic logic is_load(input sched_state_t s);
    return (s == S_LD_K) || (s == S_LD_V) || (s == S_LD_Q);
  endfunction

endpackage

// File: rtl/attention_tile_scheduler.sv
// Sequences one attention job through the attention core: K^T/V load once, then per Q tile
// load, wait out the core latency and hand the result downstream. All outputs are registered.
//
// state     | meaning
// IDLE      | waiting for start_i
// LD_K      | requesting K^T tile load
// LD_V      | requesting V tile load
// LD_Q      | requesting Q tile t load
// COMPUTE   | core pipeline running, CORE_LAT cycles
// DRAIN     | R tile t offered downstream
// FIN       | job complete, done_o pulses on exit
module attention_tile_scheduler
  import attn_sched_pkg::*;
#(
  parameter int MAX_Q_TILES = 16,
  parameter int CORE_LAT    = 6,
  parameter int TILE_W      = $clog2(MAX_Q_TILES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start_i,
  input  logic [TILE_W-1:0] num_q_tiles_i,
  input  logic              reuse_kv_i,
  input  logic              abort_i,
  output logic              ld_req_o,
  output logic [1:0]        ld_sel_o,
  output logic [TILE_W-1:0] ld_tile_o,
  input  logic              ld_ack_i,
  output logic              out_valid_o,
  output logic [TILE_W-1:0] out_tile_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              kv_loaded_o
);

  localparam int LAT_W = $clog2(CORE_LAT + 1);
  localparam logic [TILE_W-1:0] MAX_N    = TILE_W'(MAX_Q_TILES);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(CORE_LAT - 1);

  sched_state_t      state_q, state_n;
  logic [TILE_W-1:0] t_q, t_n, n_q, n_n, job_n;
  logic [LAT_W-1:0]  lat_q, lat_n;
  logic              kv_n, req_n, valid_n;
  ld_sel_t           sel_n;
  logic [TILE_W-1:0] ld_tile_n, out_tile_n;
  logic              ld_hs, out_hs, abort_act;

  assign ld_hs     = ld_req_o & ld_ack_i;
  assign out_hs    = out_valid_o & out_ready_i;
  assign abort_act = abort_i && (state_q != S_IDLE) && (state_q != S_FIN);
  assign job_n     = (num_q_tiles_i > MAX_N) ? MAX_N : num_q_tiles_i;

  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    n_n     = n_q;
    lat_n   = lat_q;
    kv_n    = kv_loaded_o;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_n = job_n;
          t_n = '0;
          if (job_n == '0) begin
            state_n = S_FIN;
          end else if (reuse_kv_i && kv_loaded_o) begin
            state_n = S_LD_Q;
          end else begin
            state_n = S_LD_K;
            kv_n    = 1'b0;
          end
        end
      end
      S_LD_K: if (ld_hs) state_n = S_LD_V;
      S_LD_V: begin
        if (ld_hs) begin
          state_n = S_LD_Q;
          kv_n    = 1'b1;
        end
      end
      S_LD_Q: begin
        if (ld_hs) begin
          state_n = S_COMPUTE;
          lat_n   = LAT_LOAD;
        end
      end
      S_COMPUTE: begin
        if (lat_q == '0) state_n = S_DRAIN;
        else             lat_n   = lat_q - 1'b1;
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (t_q == n_q - TILE_W'(1)) begin
            state_n = S_FIN;
          end else begin
            t_n     = t_q + TILE_W'(1);
            state_n = S_LD_Q;
          end
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort wins over any handshake; K/V contents are only trusted once V has landed.
    if (abort_act) begin
      state_n = S_IDLE;
      if (state_q == S_LD_K || state_q == S_LD_V) kv_n = 1'b0;
    end

    // A request acked this cycle forces one idle cycle before the next request.
    req_n      = is_load(state_n) && !ld_hs;
    sel_n      = LD_SEL_K;
    ld_tile_n  = '0;
    if (req_n) begin
      if (state_n == S_LD_V) sel_n = LD_SEL_V;
      if (state_n == S_LD_Q) begin
        sel_n     = LD_SEL_Q;
        ld_tile_n = t_n;
      end
    end
    valid_n    = (state_n == S_DRAIN) && !out_hs;
    out_tile_n = valid_n ? t_n : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      n_q         <= '0;
      lat_q       <= '0;
      kv_loaded_o <= 1'b0;
      ld_req_o    <= 1'b0;
      ld_sel_o    <= '0;
      ld_tile_o   <= '0;
      out_valid_o <= 1'b0;
      out_tile_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_n;
      t_q         <= t_n;
      n_q         <= n_n;
      lat_q       <= lat_n;
      kv_loaded_o <= kv_n;
      ld_req_o    <= req_n;
      ld_sel_o    <= sel_n;
      ld_tile_o   <= ld_tile_n;
      out_valid_o <= valid_n;
      out_tile_o  <= out_tile_n;
      busy_o      <= (state_n != S_IDLE);
      done_o      <= (state_q == S_FIN);
    end
  end

endmodule

// File: tb/tb_attention_tile_scheduler.sv
// Self-checking bench for attention_tile_scheduler: transaction-level model of load/output order,
// plus per-cycle handshake stability and latency checks against a randomized responder.
module tb_attention_tile_scheduler;

  localparam int MAXQ = 16;
  localparam int LAT  = 6;
  localparam int TW   = 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          start_i, reuse_kv_i, abort_i, ld_ack_i, out_ready_i;
  logic [TW-1:0] num_q_tiles_i;
  logic          ld_req_o, out_valid_o, busy_o, done_o, kv_loaded_o;
  logic [1:0]    ld_sel_o;
  logic [TW-1:0] ld_tile_o, out_tile_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ld_log[$];
  int out_log[$];
  int done_log[$];
  int ack_mode = 0, rdy_mode = 0;
  int ack_thr = 0, rdy_thr = 0, ld_wait = 0, rdy_wait = 0;
  int last_q = 0;
  bit model_kv = 1'b0;

  bit            prev_ok = 1'b0;
  logic          prev_req, prev_ack, prev_valid, prev_rdy;
  logic [1:0]    prev_sel;
  logic [TW-1:0] prev_tile, prev_otile;

  attention_tile_scheduler #(.MAX_Q_TILES(MAXQ), .CORE_LAT(LAT), .TILE_W(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .start_i(start_i), .num_q_tiles_i(num_q_tiles_i),
    .reuse_kv_i(reuse_kv_i), .abort_i(abort_i), .ld_req_o(ld_req_o), .ld_sel_o(ld_sel_o),
    .ld_tile_o(ld_tile_o), .ld_ack_i(ld_ack_i), .out_valid_o(out_valid_o),
    .out_tile_o(out_tile_o), .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o),
    .kv_loaded_o(kv_loaded_o)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  // Responder for ack/ready plus event logging and per-cycle protocol checks.
  always @(negedge i_clk) begin
    if (!ld_req_o) begin
      ld_ack_i = 1'b0; ld_wait = 0;
      ack_thr  = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
    end else begin
      ld_ack_i = (ld_wait >= ack_thr); ld_wait++;
    end
    if (!out_valid_o) begin
      out_ready_i = 1'b0; rdy_wait = 0;
      rdy_thr     = (rdy_mode < 0) ? int'($urandom_range(0, 3)) : rdy_mode;
    end else begin
      out_ready_i = (rdy_wait >= rdy_thr); rdy_wait++;
    end
    if (!i_rst) begin
      if (ld_req_o && ld_ack_i) begin
        ld_log.push_back(int'(ld_sel_o) * 32 + int'(ld_tile_o));
        if (ld_sel_o == 2'd2) last_q = cyc;
      end
      if (out_valid_o && out_ready_i) out_log.push_back(int'(out_tile_o));
      if (done_o) done_log.push_back(cyc);
      if (ld_req_o) begin
        checks++;
        if (ld_sel_o == 2'd3 || (ld_sel_o != 2'd2 && ld_tile_o != '0)) begin
          errors++; $display("FAIL ld_sel_legal sel=%0d tile=%0d", ld_sel_o, ld_tile_o);
        end
      end
      if (prev_ok) begin
        if (prev_req && !prev_ack && !abort_i) begin
          checks++;
          if (ld_req_o !== 1'b1 || ld_sel_o !== prev_sel || ld_tile_o !== prev_tile) begin
            errors++;
            $display("FAIL ld_hold got req=%0b sel=%0d tile=%0d want req=1 sel=%0d tile=%0d",
                     ld_req_o, ld_sel_o, ld_tile_o, prev_sel, prev_tile);
          end
        end
        if (prev_req && prev_ack) begin
          checks++;
          if (ld_req_o !== 1'b0) begin errors++; $display("FAIL ld_gap got req=%0b want 0", ld_req_o); end
        end
        if (prev_valid && !prev_rdy && !abort_i) begin
          checks++;
          if (out_valid_o !== 1'b1 || out_tile_o !== prev_otile) begin
            errors++;
            $display("FAIL out_hold got valid=%0b tile=%0d want valid=1 tile=%0d",
                     out_valid_o, out_tile_o, prev_otile);
          end
        end
        if (out_valid_o && !prev_valid) begin
          checks++;
          if (cyc - last_q != LAT + 1) begin
            errors++; $display("FAIL core_latency got %0d want %0d", cyc - last_q, LAT + 1);
          end
        end
      end
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
    prev_req = ld_req_o; prev_ack = ld_ack_i; prev_sel = ld_sel_o; prev_tile = ld_tile_o;
    prev_valid = out_valid_o; prev_rdy = out_ready_i; prev_otile = out_tile_o;
  end

  task automatic run_job(input int n, input bit reuse, input bit hold, input string name);
    int exp_ld[$];
    int nn, start_cyc;
    logic exp_req;
    nn = (n > MAXQ) ? MAXQ : n;
    if (nn > 0) begin
      if (!(reuse && model_kv)) begin exp_ld.push_back(0); exp_ld.push_back(32); end
      for (int i = 0; i < nn; i++) exp_ld.push_back(64 + i);
    end
    exp_req = (nn > 0);
    ld_log.delete(); out_log.delete(); done_log.delete();
    @(negedge i_clk); #1;
    start_i = 1'b1; num_q_tiles_i = TW'(n); reuse_kv_i = reuse; start_cyc = cyc;
    @(negedge i_clk); #2;
    if (!hold) start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || ld_req_o !== exp_req) begin
      errors++;
      $display("FAIL %s first_cycle got busy=%0b req=%0b want busy=1 req=%0b", name, busy_o, ld_req_o, exp_req);
    end
    for (int k = 0; k < 3000 && done_log.size() == 0; k++) begin @(negedge i_clk); #2; end
    start_i = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    checks++;
    if (done_log.size() != 1) begin
      errors++; $display("FAIL %s done_count got %0d want 1", name, done_log.size());
    end
    if (nn == 0 && done_log.size() > 0) begin
      checks++;
      if (done_log[0] - start_cyc != 2) begin
        errors++; $display("FAIL %s done_delay got %0d want 2", name, done_log[0] - start_cyc);
      end
    end
    checks++;
    if (ld_log.size() != exp_ld.size()) begin
      errors++; $display("FAIL %s load_count got %0d want %0d", name, ld_log.size(), exp_ld.size());
    end else begin
      foreach (exp_ld[i]) begin
        checks++;
        if (ld_log[i] != exp_ld[i]) begin
          errors++; $display("FAIL %s load[%0d] got sel*32+tile=%0d want %0d", name, i, ld_log[i], exp_ld[i]);
        end
      end
    end
    checks++;
    if (out_log.size() != nn) begin
      errors++; $display("FAIL %s out_count got %0d want %0d", name, out_log.size(), nn);
    end else begin
      foreach (out_log[i]) begin
        checks++;
        if (out_log[i] != i) begin
          errors++; $display("FAIL %s out_tile[%0d] got %0d want %0d", name, i, out_log[i], i);
        end
      end
    end
    if (nn > 0) model_kv = 1'b1;
    checks++;
    if (kv_loaded_o !== model_kv || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state got kv=%0b busy=%0b want kv=%0b busy=0", name, kv_loaded_o, busy_o, model_kv);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; start_i = 0; num_q_tiles_i = '0; reuse_kv_i = 0; abort_i = 0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({ld_req_o, ld_sel_o, ld_tile_o, out_valid_o, out_tile_o, busy_o, done_o, kv_loaded_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero output while in reset");
    end
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({ld_req_o, out_valid_o, busy_o, done_o, kv_loaded_o} !== '0) begin
      errors++; $display("FAIL reset_idle got nonzero output after release");
    end
  endtask

  task automatic wait_for_load(input logic [1:0] sel, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (ld_req_o && ld_sel_o == sel) begin found = 1'b1; break; end
      @(negedge i_clk); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL %s wait_load got none want sel=%0d", name, sel); end
  endtask

  task automatic test_abort_ldv();
    ack_mode = 0; rdy_mode = 0; done_log.delete();
    @(negedge i_clk); #1 start_i = 1; num_q_tiles_i = 5'd2; reuse_kv_i = 0;
    @(negedge i_clk); #1 start_i = 0;
    wait_for_load(2'd1, "abort_ldv");
    abort_i = 1'b1;
    @(negedge i_clk); #1 abort_i = 1'b0;
    model_kv = 1'b0;
    checks++;
    if (busy_o !== 0 || ld_req_o !== 0 || out_valid_o !== 0 || kv_loaded_o !== model_kv) begin
      errors++;
      $display("FAIL abort_ldv got busy=%0b req=%0b valid=%0b kv=%0b want all 0", busy_o, ld_req_o, out_valid_o, kv_loaded_o);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (done_log.size() != 0 || busy_o !== 0) begin
      errors++; $display("FAIL abort_ldv_nodone got done=%0d busy=%0b want 0 0", done_log.size(), busy_o);
    end
  endtask

  task automatic test_abort_drain();
    bit found = 1'b0;
    ack_mode = 0; rdy_mode = 40; done_log.delete();
    @(negedge i_clk); #1 start_i = 1; num_q_tiles_i = 5'd3; reuse_kv_i = 1;
    @(negedge i_clk); #1 start_i = 0;
    for (int k = 0; k < 300; k++) begin
      if (out_valid_o && out_tile_o == 5'd1) begin found = 1'b1; break; end
      @(negedge i_clk); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_drain wait_tile1 got none want tile 1"); end
    abort_i = 1'b1;
    @(negedge i_clk); #1 abort_i = 1'b0;
    model_kv = 1'b1;
    checks++;
    if (busy_o !== 0 || out_valid_o !== 0 || kv_loaded_o !== model_kv) begin
      errors++;
      $display("FAIL abort_drain got busy=%0b valid=%0b kv=%0b want 0 0 1", busy_o, out_valid_o, kv_loaded_o);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (done_log.size() != 0) begin errors++; $display("FAIL abort_drain_nodone got %0d want 0", done_log.size()); end
    rdy_mode = 0;
  endtask

  task automatic test_async_reset();
    ack_mode = 0; rdy_mode = 0;
    @(negedge i_clk); #1 start_i = 1; num_q_tiles_i = 5'd2; reuse_kv_i = 0;
    @(negedge i_clk); #1 start_i = 0;
    wait_for_load(2'd2, "async_reset");
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    model_kv = 1'b0;
    checks++;
    if ({ld_req_o, ld_sel_o, ld_tile_o, out_valid_o, out_tile_o, busy_o, done_o, kv_loaded_o} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%0b kv=%0b want all outputs 0", busy_o, kv_loaded_o);
    end
    @(negedge i_clk); #1 i_rst = 1'b0;
    run_job(1, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    ack_mode = -1; rdy_mode = -1;
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0, "random");
    ack_mode = 0; rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    ack_mode = 0; rdy_mode = 0;
    run_job(3, 1'b0, 1'b0, "basic");
    run_job(2, 1'b1, 1'b0, "reuse");
    run_job(0, 1'b0, 1'b0, "zero_tiles");
    ack_mode = 5; rdy_mode = 4;
    run_job(3, 1'b0, 1'b1, "stall");
    test_abort_ldv();
    test_abort_drain();
    ack_mode = 0; rdy_mode = 0;
    run_job(31, 1'b1, 1'b0, "clamp");
    run_job(2, 1'b0, 1'b0, "back_to_back");
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
